fp_exponent_logic: RTL and testbench
====================================

# fp_exponent_logic

Exponent datapath of the floating-point multiply/divide unit. It takes the two 8-bit biased exponents of the operands and forms the biased result exponent: sum minus bias for multiply, difference plus bias for divide. The result is a 10-bit two's-complement value held in an enabled output register. The two extra bits let the downstream normalise/round stage detect overflow (≥255) and underflow (≤0) without losing information.

## Interface
Parameters:
- EXP_W, 8, operand exponent width; result width is EXP_W+2.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- arst  input  1  reset, asynchronous, active-low; 0 clears all state immediately.
- en  input  1  load enable; 1 lets the pipeline advance on a clk edge.
- sel  input  1  operation select; 0 = multiply, 1 = divide.
- e_a  input  EXP_W  biased exponent of operand A (unsigned).
- e_b  input  EXP_W  biased exponent of operand B (unsigned).
- e  output  EXP_W+2  registered biased result exponent, two's complement.

## Operation
- Zero-extend e_a and e_b to EXP_W+2 bits. BIAS is an EXP_W+2-bit constant.
- sel=0 (multiply): r = e_a + e_b − BIAS.
- sel=1 (divide): r = e_a − e_b + BIAS.
- All arithmetic is modulo 2^(EXP_W+2). With the defaults no wrap occurs:
  - multiply range is −127..383 (0x381..0x17F);
  - divide range is −128..382 (0x380..0x17E).
- No saturation or clamping. Special exponents (0, 255) are not special-cased; the upstream classifier handles zero/inf/NaN.
- Single shared adder with operand-B negation and bias sign muxed by sel; sel only affects the value being computed.
- e is the only state in the default build; X on an input propagates only when en=1.

## Timing
- Reset value: e = 0.
- Reset is asserted asynchronously and released synchronously-safe; any internal stage registers also reset to 0.
- Latency 1 cycle (default build):
  - e reflects the e_a/e_b/sel sampled at a rising edge where en=1;
  - the value is visible right after that edge.
- en=0 at an edge: e holds its value, and input changes are ignored.
- en and sel are sampled at the same edge as e_a/e_b; no handshake, a new operation can be accepted every cycle.
- Reset mid-operation: arst going low between edges forces e=0 at once. After arst returns high, e stays 0 until the first edge with en=1.
- Simultaneous reset and en=1 edge: reset wins.

## Configuration
- Macro EXP_INPUT_REG_EN.
- Defined:
  - an input register stage captures e_a, e_b and sel on edges with en=1;
  - the output register loads the result computed from that stage on the same enabled edges;
  - latency is 2 enabled edges, and en=0 stalls both stages;
  - all stages reset to 0, so e=0 until two enabled edges have occurred after reset.
- Not defined: single output register, latency 1, as described in Timing.

## Test plan
- Async reset: drive arst=0 with no clk edge -> e=0x000 immediately; hold arst=0 with en=1 for several edges -> e stays 0.
- Multiply: en=1, sel=0, e_a=130, e_b=125 -> e=0x080 (128) after 1 edge; e_a=0, e_b=0 -> e=0x381 (−127); e_a=255, e_b=255 -> e=0x17F (383).
- Divide: en=1, sel=1, e_a=255, e_b=0 -> e=0x17E (382); e_a=0, e_b=255 -> e=0x380 (−128); e_a=e_b=100 -> e=0x07F.
- Enable hold: load e=0x080, then en=0 while randomising e_a/e_b/sel for 10 edges -> e stays 0x080; next edge with en=1 loads the new result.
- Reset mid-stream: random en/sel/e_a/e_b every cycle, with arst pulsed low between edges for 2–3 cycles -> e=0 during the pulse. After release, e matches the reference model from the first enabled edge (second enabled edge with EXP_INPUT_REG_EN).
- Random regression: 1000 cycles of random inputs, en held 1, sel 0 then 1 -> e equals the model result each cycle with the configured latency.

Source files
------------

// File: rtl/fp_exponent_logic.sv
// Exponent datapath for FP multiply/divide: biased result exponent, 10-bit two's complement.
// Define EXP_INPUT_REG_EN to add an input register stage (latency 2 enabled edges).
module fp_exponent_logic #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned BIAS  = 127
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             sel,
  input  logic [EXP_W-1:0] e_a,
  input  logic [EXP_W-1:0] e_b,
  output logic [EXP_W+1:0] e
);

  localparam int unsigned RW = EXP_W + 2;
  localparam logic [RW-1:0] BiasC = RW'(BIAS);

  logic             op_sel;
  logic [EXP_W-1:0] op_a;
  logic [EXP_W-1:0] op_b;

`ifdef EXP_INPUT_REG_EN
  logic             sel_q;
  logic [EXP_W-1:0] a_q;
  logic [EXP_W-1:0] b_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sel_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (en) begin
      sel_q <= sel;
      a_q   <= e_a;
      b_q   <= e_b;
    end
  end

  assign op_sel = sel_q;
  assign op_a   = a_q;
  assign op_b   = b_q;
`else
  assign op_sel = sel;
  assign op_a   = e_a;
  assign op_b   = e_b;
`endif

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_op;
  logic [RW-1:0] bias_op;
  logic [RW-1:0] cin;
  logic [RW-1:0] r_d;

  // One adder: divide inverts B (with carry-in) and adds +BIAS; multiply adds -BIAS.
  always_comb begin
    a_ext   = {2'b00, op_a};
    b_op    = op_sel ? ~{2'b00, op_b} : {2'b00, op_b};
    bias_op = op_sel ? BiasC : (~BiasC + RW'(1));
    cin     = {{(RW-1){1'b0}}, op_sel};
    r_d     = a_ext + b_op + bias_op + cin;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      e <= '0;
    end else if (en) begin
      e <= r_d;
    end
  end

endmodule

// File: tb/tb_fp_exponent_logic.sv
// Self-checking bench for fp_exponent_logic: directed vectors, reset/enable sequences, random model.
module tb_fp_exponent_logic;

  localparam int EXP_W = 8;
  localparam int BIAS  = 127;

  logic       clk = 1'b0;
  logic       arst;
  logic       en;
  logic       sel;
  logic [7:0] e_a;
  logic [7:0] e_b;
  logic [9:0] e;

  int errors = 0;
  int checks = 0;

  // Reference state: expected output and (when configured) the captured input stage.
  logic [9:0] m_e;
  logic       m_sel;
  logic [7:0] m_a;
  logic [7:0] m_b;

  typedef struct {
    string      name;
    bit         s;
    logic [7:0] a;
    logic [7:0] b;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  fp_exponent_logic #(
    .EXP_W(EXP_W),
    .BIAS (BIAS)
  ) dut (
    .clk (clk),
    .arst(arst),
    .en  (en),
    .sel (sel),
    .e_a (e_a),
    .e_b (e_b),
    .e   (e)
  );

  function automatic logic [9:0] ref_f(input bit s, input logic [7:0] a, input logic [7:0] b);
    int r;
    if (s) r = int'(a) - int'(b) + BIAS;
    else   r = int'(a) + int'(b) - BIAS;
    return 10'(r);
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e   = '0;
    m_sel = 1'b0;
    m_a   = '0;
    m_b   = '0;
  endtask

  // Drive inputs away from the edge, take one edge, update model, sample 1 time unit later.
  task automatic step(input bit en_v, input bit s, input logic [7:0] a, input logic [7:0] b,
                      input string name);
    en  = en_v;
    sel = s;
    e_a = a;
    e_b = b;
    @(posedge clk);
    if (arst && en_v) begin
`ifdef EXP_INPUT_REG_EN
      m_e   = ref_f(m_sel, m_a, m_b);
      m_sel = s;
      m_a   = a;
      m_b   = b;
`else
      m_e = ref_f(s, a, b);
`endif
    end
    #1;
    check(name, e, m_e);
  endtask

  task automatic apply_vec(input vec_t v);
    step(1'b1, v.s, v.a, v.b, "model");
`ifdef EXP_INPUT_REG_EN
    step(1'b1, v.s, v.a, v.b, "model");
`endif
    check(v.name, e, v.exp);
  endtask

  initial begin
    vecs[0] = '{name: "mul_130_125", s: 1'b0, a: 8'd130, b: 8'd125, exp: 10'h080};
    vecs[1] = '{name: "mul_0_0",     s: 1'b0, a: 8'd0,   b: 8'd0,   exp: 10'h381};
    vecs[2] = '{name: "mul_255_255", s: 1'b0, a: 8'd255, b: 8'd255, exp: 10'h17F};
    vecs[3] = '{name: "div_255_0",   s: 1'b1, a: 8'd255, b: 8'd0,   exp: 10'h17E};
    vecs[4] = '{name: "div_0_255",   s: 1'b1, a: 8'd0,   b: 8'd255, exp: 10'h380};
    vecs[5] = '{name: "div_100_100", s: 1'b1, a: 8'd100, b: 8'd100, exp: 10'h07F};

    arst = 1'b1;
    en   = 1'b0;
    sel  = 1'b0;
    e_a  = '0;
    e_b  = '0;
    model_reset();

    // Asynchronous assertion with no clock edge in between.
    #2;
    arst = 1'b0;
    #1;
    check("async_reset", e, 10'h000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd200, 8'd200, "reset_hold");
    arst = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Enable hold: en=0 with random inputs leaves the result untouched.
    apply_vec(vecs[0]);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), "model");
      check("en_hold", e, 10'h080);
    end
    step(1'b1, 1'b1, 8'd10, 8'd20, "model");
`ifdef EXP_INPUT_REG_EN
    step(1'b1, 1'b1, 8'd10, 8'd20, "model");
`endif
    check("en_reload", e, ref_f(1'b1, 8'd10, 8'd20));

    // Random traffic with a mid-stream reset pulse between edges.
    for (int c = 0; c < 60; c++) begin
      if (c == 20) begin
        arst = 1'b0;
        model_reset();
        #1;
        check("rst_pulse", e, 10'h000);
      end
      if (c == 20 + 2 + int'($urandom_range(0, 1))) arst = 1'b1;
      step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), "model");
      if (!arst) check("rst_pulse_hold", e, 10'h000);
    end
    arst = 1'b1;

    // Random regression: en held high, multiply then divide.
    for (int c = 0; c < 1000; c++) begin
      step(1'b1, (c >= 500), 8'($urandom), 8'($urandom), "model");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
